// File: rtl/ntt_stage_scheduler.sv
// Issue sequencer for a three-stage NTT: walks (p,k) through stages p=2,1,0
// with configurable bubble cycles between stages and a drain tail before done.
module ntt_stage_scheduler #(
    parameter int STAGE_GAP    = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic [4:0] k,
    output logic [3:0] p,
    output logic       valid,
    output logic       stage_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] GAP_END   = 4'(STAGE_GAP - 1);
    localparam logic [3:0] DRAIN_END = 4'(DRAIN_CYCLES - 1);
    localparam bit         HAS_GAP   = (STAGE_GAP > 0);
    localparam bit         HAS_DRAIN = (DRAIN_CYCLES > 0);

    state_t     state_r, state_s;
    logic [4:0] k_r, k_s;
    logic [3:0] p_r, p_s;
    logic [3:0] gap_cnt_r, gap_cnt_s;
    logic [3:0] drain_cnt_r, drain_cnt_s;
    logic       busy_r, done_r;
    logic       valid_s, last_s;

    // Stage p issues 2^(5-2p) butterflies: p=2 -> 2, p=1 -> 8, p=0 -> 32.
    function automatic logic [4:0] stage_max(input logic [3:0] stage);
        logic [4:0] m;
        case (stage)
            4'd2:    m = 5'd1;
            4'd1:    m = 5'd7;
            default: m = 5'd31;
        endcase
        return m;
    endfunction

    assign valid_s = (state_r == RUN) & ~hold;
    assign last_s  = valid_s & (k_r == stage_max(p_r));

    // Next-state, index and counter logic.
    always_comb begin
        state_s     = state_r;
        k_s         = k_r;
        p_s         = p_r;
        gap_cnt_s   = gap_cnt_r;
        drain_cnt_s = drain_cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    k_s     = 5'd0;
                    p_s     = 4'd2;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!valid_s) begin
                    state_s = RUN;
                end else if (last_s && (p_r != 4'd0)) begin
                    p_s       = p_r - 4'd1;
                    k_s       = 5'd0;
                    gap_cnt_s = 4'd0;
                    state_s   = HAS_GAP ? GAP : RUN;
                end else if (last_s) begin
                    p_s         = 4'd0;
                    k_s         = 5'd0;
                    drain_cnt_s = 4'd0;
                    state_s     = HAS_DRAIN ? DRAIN : DONE;
                end else begin
                    k_s = k_r + 5'd1;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_END) begin
                    state_s = RUN;
                end else begin
                    gap_cnt_s = gap_cnt_r + 4'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_END) begin
                    state_s = DONE;
                end else begin
                    drain_cnt_s = drain_cnt_r + 4'd1;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, index and status registers; busy/done follow the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            k_r         <= 5'd0;
            p_r         <= 4'd0;
            gap_cnt_r   <= 4'd0;
            drain_cnt_r <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            p_r         <= p_s;
            gap_cnt_r   <= gap_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
        end
    end

    assign k          = k_r;
    assign p          = p_r;
    assign valid      = valid_s;
    assign stage_last = last_s;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: doc/ntt_stage_scheduler.md
NTT_STAGE_SCHEDULER -- requirements
Module: ntt_stage_scheduler

Interface
REQ-001 SHALL have parameter STAGE_GAP, default 2, meaning the number of idle bubble cycles inserted between consecutive stages (0..15 legal).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of cycles waited after the last issue before done (0..15 legal).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port hold  input  1  back-pressure; freezes issue while in RUN.
REQ-007 SHALL have port k  output  5  butterfly/twiddle index within the current stage, to the twiddle address generator.
REQ-008 SHALL have port p  output  4  current stage number, to the twiddle address generator.
REQ-009 SHALL have port valid  output  1  the current (p,k) is an issued butterfly this cycle.
REQ-010 SHALL have port stage_last  output  1  the current issue is the final k of its stage.
REQ-011 SHALL have port busy  output  1  a run is in progress (any state except IDLE).
REQ-012 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN, GAP, DRAIN and DONE.
REQ-014 SHALL issue the stages in the order p=2, p=1, p=0, with k ranging 0..1, 0..7 and 0..31 respectively (42 issues per run).
REQ-015 SHALL, in IDLE with start=1 at an edge, load p=2, k=0 and enter RUN; start SHALL be ignored in all other states.
REQ-016 SHALL drive valid = (state==RUN) & ~hold combinationally; k and p SHALL be registered.
REQ-017 SHALL, in RUN with hold=0, advance k by 1 each edge; with hold=1, k, p and the state SHALL be unchanged.
REQ-018 SHALL drive stage_last = valid & (k == last index of stage p).
REQ-019 SHALL, on an issued stage_last with p>0, set p<=p-1 and k<=0, and enter GAP if STAGE_GAP>0 or stay in RUN otherwise (back-to-back stages).
REQ-020 SHALL keep GAP for exactly STAGE_GAP cycles with valid=0, and SHALL then enter RUN; hold SHALL NOT affect GAP.
REQ-021 SHALL, on an issued stage_last with p=0, enter DRAIN if DRAIN_CYCLES>0 or DONE otherwise; k and p SHALL remain 0 from then on.
REQ-022 SHALL keep DRAIN for exactly DRAIN_CYCLES cycles with hold ignored, and SHALL then enter DONE.
REQ-023 SHALL keep DONE for exactly one cycle with done=1, then return to IDLE; a start asserted during DONE SHALL be ignored.
REQ-024 SHALL use 4-bit gap and drain counters; the k compare SHALL be on the 5-bit value, with no wrap beyond the stage maximum.
REQ-025 SHALL assert busy in RUN, GAP, DRAIN and DONE, and deassert it in IDLE.

Reset
REQ-026 SHALL, when rst=0 at any edge (including mid-run), force state IDLE with k=0, p=0, valid=0, stage_last=0, busy=0, done=0, and clear both counters.
REQ-027 SHALL ignore start on any edge where rst=0; the first legal start is the edge after rst returns to 1.

Verification
REQ-028 SHALL cover a nominal run (defaults) with start pulsed at edge E0 -> valid high in cycles 1-2 (p=2,k=0,1), 5-12 (p=1), 15-46 (p=0), done=1 only in cycle 50, busy cycles 1-50, exactly 42 valid cycles.
REQ-029 SHALL cover hold=1 for 4 cycles while p=1,k=3 -> valid=0 and k=3,p=1 frozen for 4 cycles, then resume at k=3, with done delayed by exactly 4 cycles (cycle 54).
REQ-030 SHALL cover STAGE_GAP=0 and DRAIN_CYCLES=0 -> 42 contiguous valid cycles 1-42, stage_last in cycles 2, 10 and 42, done in cycle 43.
REQ-031 SHALL cover rst=0 asserted in cycle 20 of a run -> all outputs 0 the next cycle, state IDLE, and a subsequent start begins at p=2,k=0.
REQ-032 SHALL cover start held high continuously -> a new run begins only on the edge after DONE returns to IDLE, with no issue overlap between runs.
REQ-033 SHALL cover hold=1 during GAP and DRAIN -> no effect on their durations.
